fadd_operand_loader: RTL and testbench

FADD_OPERAND_LOADER -- requirements
Module: fadd_operand_loader

---
 rtl/fadd_operand_loader.sv | 135 +++++++++++++
 tb/tb_fadd_operand_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fadd_operand_loader.sv
// Collects two big-endian 32-bit operands from a UART byte stream, hands them to fadd and returns its answer.
// Optional inter-byte timeout is built when FADD_LOADER_TIMEOUT_EN is defined.
module fadd_operand_loader #(
    parameter int TIMEOUT_CYCLES = 104160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rdata,
    input  logic        rdata_ready,
    input  logic        ferr,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic        input_ready,
    input  logic [31:0] answer,
    input  logic        answer_ready,
    output logic        received,
    output logic [31:0] result,
    output logic        result_valid,
    output logic [1:0]  err_flags
);

    localparam logic [1:0] S_OP1   = 2'd0;
    localparam logic [1:0] S_OP2   = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  err_q, err_d;
    logic        ack_q, ack_d;
    logic        accept;

`ifdef FADD_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_run;
    logic             tmo_hit;

    // The timer only runs while a pair is partially received.
    assign tmo_run = ((state_q == S_OP1) && (cnt_q != 2'd0)) || (state_q == S_OP2);
    assign tmo_hit = tmo_run && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    assign accept = rdata_ready && !ferr && ((state_q == S_OP1) || (state_q == S_OP2));

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        err_d    = err_q;
        ack_d    = (state_q == S_ACK);
`ifdef FADD_LOADER_TIMEOUT_EN
        tmo_d    = (accept || !tmo_run) ? '0 : tmo_q + TMO_W'(1);
`endif
        case (state_q)
            S_OP1, S_OP2: begin
                if (rdata_ready) begin
                    if (ferr) begin
                        err_d[0] = 1'b1;
                        cnt_d    = 2'd0;
                        state_d  = S_OP1;
                    end else begin
                        if (state_q == S_OP1) op1_d = {op1_q[23:0], rdata};
                        else                  op2_d = {op2_q[23:0], rdata};
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) state_d = (state_q == S_OP1) ? S_OP2 : S_ISSUE;
                    end
                end
`ifdef FADD_LOADER_TIMEOUT_EN
                else if (tmo_hit) begin
                    cnt_d   = 2'd0;
                    state_d = S_OP1;
                end
`endif
            end
            S_ISSUE: begin
                if (rdata_ready) err_d[1] = 1'b1;
                if (answer_ready) begin
                    result_d = answer;
                    state_d  = S_ACK;
                end
            end
            default: begin
                if (rdata_ready) err_d[1] = 1'b1;
                state_d = S_OP1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
        if (rst) begin
            state_q  <= S_OP1;
            cnt_q    <= 2'd0;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            result_q <= 32'd0;
            err_q    <= 2'b00;
            ack_q    <= 1'b0;
`ifdef FADD_LOADER_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
`ifdef FADD_LOADER_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign operand1     = op1_q;
    assign operand2     = op2_q;
    assign input_ready  = (state_q == S_ISSUE);
    assign received     = ack_q;
    assign result_valid = ack_q;
    assign result       = result_q;
    assign err_flags    = err_q;

endmodule

// File: tb/tb_fadd_operand_loader.sv
// Directed self-checking bench for fadd_operand_loader; with FADD_LOADER_TIMEOUT_EN it runs the timeout case.
module tb_fadd_operand_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic        rdata_ready = 1'b0;
    logic        ferr = 1'b0;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        input_ready;
    logic [31:0] answer = 32'h0;
    logic        answer_ready = 1'b0;
    logic        received;
    logic [31:0] result;
    logic        result_valid;
    logic [1:0]  err_flags;

    int checks = 0;
    int errors = 0;

`ifdef FADD_LOADER_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 104160;
`endif

    fadd_operand_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdata        (rdata),
        .rdata_ready  (rdata_ready),
        .ferr         (ferr),
        .operand1     (operand1),
        .operand2     (operand2),
        .input_ready  (input_ready),
        .answer       (answer),
        .answer_ready (answer_ready),
        .received     (received),
        .result       (result),
        .result_valid (result_valid),
        .err_flags    (err_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one byte for a single cycle starting at the current falling edge.
    task automatic send_byte(input logic [7:0] b, input logic fe);
        rdata       = b;
        ferr        = fe;
        rdata_ready = 1'b1;
        @(negedge clk);
        rdata_ready = 1'b0;
        ferr        = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_op1"}, operand1, 32'h0);
        check({tag, "_op2"}, operand2, 32'h0);
        check({tag, "_res"}, result, 32'h0);
        check({tag, "_err"}, {30'd0, err_flags}, 32'h0);
        check({tag, "_irdy"}, {31'd0, input_ready}, 32'h0);
        check({tag, "_rcvd"}, {31'd0, received}, 32'h0);
        check({tag, "_rval"}, {31'd0, result_valid}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Sends the last nbytes of {o1,o2}, raises answer_ready in S_ISSUE cycle d,
    // optionally injects a byte in cycle inj, and checks the handshake timing.
    task automatic txn(input string tag, input logic [31:0] o1, input logic [31:0] o2,
                       input logic [31:0] ans, input int nbytes, input int d, input int inj,
                       input int exp_lat, input logic [1:0] exp_err);
        logic [63:0] stream;
        int lat;
        int ir_cnt;
        logic got;
        stream = {o1, o2};
        for (int i = 8 - nbytes; i < 8; i++) send_byte(stream[63-8*i -: 8], 1'b0);
        lat = 0;
        ir_cnt = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            lat++;
            if (input_ready) ir_cnt++;
            if (received) begin
                got = 1'b1;
                check({tag, "_rval"}, {31'd0, result_valid}, 32'h1);
                check({tag, "_res"}, result, ans);
            end else begin
                answer       = ans;
                answer_ready = (lat == d);
                rdata        = 8'hAA;
                rdata_ready  = (lat == inj);
                @(negedge clk);
            end
        end
        answer_ready = 1'b0;
        rdata_ready  = 1'b0;
        check({tag, "_got_rcvd"}, {31'd0, got}, 32'h1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_irdy_cycles"}, ir_cnt, d);
        @(negedge clk);
        check({tag, "_rcvd_once"}, {31'd0, received}, 32'h0);
        check({tag, "_rval_once"}, {31'd0, result_valid}, 32'h0);
        check({tag, "_irdy_low"}, {31'd0, input_ready}, 32'h0);
        check({tag, "_op1"}, operand1, o1);
        check({tag, "_op2"}, operand2, o2);
        check({tag, "_err"}, {30'd0, err_flags}, {30'd0, exp_err});
    endtask

    initial begin
        int seen;
        @(negedge clk);
        do_reset("rst0");

        // 1.0 + 2.0 = 3.0, answer in the fifth S_ISSUE cycle.
        txn("basic", 32'h3F800000, 32'h40000000, 32'h40400000, 8, 5, 0, 7, 2'b00);
        // Fastest handshake: received three cycles after the 8th byte.
        txn("minlat", 32'h12345678, 32'h9ABCDEF0, 32'hCAFEF00D, 8, 1, 0, 3, 2'b00);

        // Framing error on the third byte restarts the whole pair.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        check("ferr_flag", {30'd0, err_flags}, 32'h1);
        check("ferr_noissue", {31'd0, input_ready}, 32'h0);
        txn("ferr", 32'hC1200000, 32'h41A00000, 32'h40C00000, 8, 2, 0, 4, 2'b01);

        // Byte during S_ISSUE is dropped and flagged as overrun.
        do_reset("rst1");
        txn("ovr", 32'hDEADBEEF, 32'h01020304, 32'h55AA55AA, 8, 4, 2, 6, 2'b10);
        // Overrun coinciding with answer_ready: both take effect.
        do_reset("rst2");
        txn("coin", 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 8, 3, 3, 5, 2'b10);

        // Reset while input_ready is high abandons the transaction.
        for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i), 1'b0);
        check("abort_irdy", {31'd0, input_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        answer = 32'h77777777;
        answer_ready = 1'b1;
        check("abort_irdy_low", {31'd0, input_ready}, 32'h0);
        check("abort_op1", operand1, 32'h0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (received || input_ready) seen++;
        end
        answer_ready = 1'b0;
        check("abort_no_rcvd", seen, 0);
        check("abort_res", result, 32'h0);
        txn("after_abort", 32'h3F000000, 32'h3F000000, 32'h3F800000, 8, 2, 0, 4, 2'b00);

`ifdef FADD_LOADER_TIMEOUT_EN
        // A partial pair is dropped after the inter-byte timeout.
        send_byte(8'hEE, 1'b0);
        send_byte(8'hFF, 1'b0);
        repeat (100) @(negedge clk);
        txn("tmo", 32'h40490FDB, 32'h402DF854, 32'h40B8C617, 8, 2, 0, 4, 2'b00);
`else
        // Without the timeout a partial pair waits indefinitely.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        repeat (150) @(negedge clk);
        check("wait_noissue", {31'd0, input_ready}, 32'h0);
        txn("wait", 32'h11223344, 32'h55667788, 32'h99AABBCC, 6, 2, 0, 4, 2'b00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
